traffic_request_conditioner: RTL and testbench
==============================================

# traffic_request_conditioner

Input stage for the four-way traffic light controller. It synchronises and debounces four raw pedestrian push-buttons (north, east, south, west) and latches each press as a pending request. A request stays pending until the controller acknowledges that direction. A round-robin arbiter tells the controller which pending direction to serve next.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 2_000_000, consecutive clk cycles a synchronised input must differ from its debounced value before the debounced value changes (20 ms at 100 MHz); legal range ≥ 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, single clock domain; all state on rising edge.
- rst  in  1  asynchronous active-low reset (0 = reset), deassertion synchronous to clk at system level.
- btn  in  4  raw asynchronous buttons, active-high; bit0 N, bit1 E, bit2 S, bit3 W.
- ack  in  4  controller service acknowledge, one cycle per served direction, same bit order.
- req  out  4  latched pending requests, registered.
- next_valid  out  1  high when any req bit is set.
- next_dir  out  2  direction to serve next (0 N, 1 E, 2 S, 3 W); valid only when next_valid.
- pending_cnt  out  3  population count of req (0..4).

## Operation
- Synchroniser: per bit, two flops s1 → s2, both reset to 0.
- Debounce, per channel: registers db (debounced level) and cnt[CNT_W-1:0].
  - s2 == db: cnt ← 0.
  - s2 != db and cnt < DEBOUNCE_CYCLES-1: cnt ← cnt+1.
  - s2 != db and cnt == DEBOUNCE_CYCLES-1: db ← s2, cnt ← 0.
  - A deviation on s2 lasting fewer than DEBOUNCE_CYCLES cycles never changes db. Any return to the db level restarts the count from 0.
- Press event: the cycle in which db commits 0→1. Release (1→0) commits silently and never affects req.
- Request latch, per bit, in priority order:
  - press: req ← 1. A press wins over a simultaneous ack, so a press that coincides with service counts as a new request.
  - else ack: req ← 0.
  - else hold. An ack on a bit with req = 0 is ignored.
- Round-robin state last[1:0], reset value 3, so north has top priority after reset.
  - On any cycle with ack ≠ 0, last ← index of the highest-numbered set ack bit.
  - ack is expected one-hot. Multi-bit ack is legal: it clears all named bits.
- Arbiter (combinational from registered req and last): next_dir = first set req bit searching last+1, last+2, last+3, last+4 (mod 4). next_valid = |req.
- pending_cnt = popcount(req), combinational from registers.

## Timing
- Reset (rst = 0, asynchronous):
  - s1, s2, db, cnt, req all 0; last = 3.
  - Outputs: req = 0, next_valid = 0, next_dir = 0, pending_cnt = 0.
  - Reset mid-debounce or with requests pending discards everything; no pending state survives.
- A button held through reset release is debounced afresh and produces one press event.
- Press latency, btn steady high from before edge 0:
  - s1 = 1 at edge 0, s2 = 1 at edge 1.
  - cnt counts edges 2..DEBOUNCE_CYCLES.
  - db and req rise together at edge DEBOUNCE_CYCLES+1.
- Release latency is identical in structure: db falls at edge DEBOUNCE_CYCLES+1.
- ack → req clear: the req bit is 0 after the same edge that samples ack. next_dir, next_valid and pending_cnt reflect it in the same cycle.
- A new last value affects next_dir in the cycle after the acking edge.
- Channels are independent: simultaneous presses on several channels all latch in the same cycle.
- Counter never wraps: maximum value DEBOUNCE_CYCLES-1.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset: drive rst = 0 with btn = 4'hF mid-run → all outputs 0 immediately. After release with btn held, req = 4'hF at edge 5 after the first sampling edge, pending_cnt = 4, next_dir = 0.
- Debounce: pulse btn[1] high for 3 cycles → req stays 0. Hold it 10 cycles → req[1] rises exactly at edge 5; release → req[1] stays 1.
- Bounce: btn[2] toggling 1,1,0,1,1,1,1 → cnt restarts on the 0. req[2] rises 5 edges after the final run of 1s begins.
- Round-robin: req = 4'hB (N, E, W pending), last = 3 → next_dir = 0. ack = 4'h1 → next_dir = 1. ack = 4'h2 → next_dir = 3. ack = 4'h8 → next_valid = 0.
- Collision: db[0] press commit on the same edge as ack[0] → req[0] stays 1 and last = 0. Ack on an idle bit → req unchanged, last updated.
- Multi-ack: req = 4'hF, ack = 4'h5 → req = 4'hA, last = 2, next_dir = 3, pending_cnt = 2.

Source files
------------

// File: rtl/traffic_request_conditioner.sv
// traffic_request_conditioner
//
// Input stage for the four-way traffic light controller. It synchronises and
// debounces four raw pedestrian push-buttons, latches each press as a pending
// request until the controller acknowledges that direction, and runs a
// round-robin arbiter that names the pending direction to serve next.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   rst          asynchronous active-low reset (0 = reset)
//   btn[3:0]     raw asynchronous buttons, active-high (bit0 N, 1 E, 2 S, 3 W)
//   ack[3:0]     service acknowledge from the controller, same bit order
//   req[3:0]     latched pending requests (registered)
//   next_valid   high when any request is pending
//   next_dir     direction to serve next (0 N, 1 E, 2 S, 3 W), valid with next_valid
//   pending_cnt  number of pending requests (0..4)

module traffic_request_conditioner #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic [3:0] ack,
  output logic [3:0] req,
  output logic       next_valid,
  output logic [1:0] next_dir,
  output logic [2:0] pending_cnt
);

  // Terminal count: the debounced level flips on the edge where the counter
  // already holds this value, so it never wraps.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]            s1_q, s1_d;
  logic [3:0]            s2_q, s2_d;
  logic [3:0]            db_q, db_d;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]            req_q, req_d;
  logic [1:0]            last_q, last_d;
  logic [3:0]            press;

  // Two-flop synchroniser per button.
  always_comb begin
    s1_d = btn;
    s2_d = s1_q;
  end

  // Debounce: any sample equal to the debounced level restarts the count, so
  // only an unbroken run of DEBOUNCE_CYCLES differing samples commits a change.
  // A press is a 0->1 commit; releases commit without any further effect.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    press = '0;
    for (int i = 0; i < 4; i++) begin
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          db_d[i]  = s2_q[i];
          press[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // A press wins over a simultaneous ack so a button pushed while its
  // direction is being served is kept as a fresh request.
  always_comb begin
    req_d = press | (req_q & ~ack);
  end

  // Round-robin pointer follows the highest-numbered acked direction; the
  // ascending loop lets the highest set bit overwrite lower ones.
  always_comb begin
    last_d = last_q;
    for (int i = 0; i < 4; i++) begin
      if (ack[i]) begin
        last_d = 2'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      db_q   <= '0;
      cnt_q  <= '0;
      req_q  <= '0;
      last_q <= 2'd3;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
      req_q  <= req_d;
      last_q <= last_d;
    end
  end

  // Arbiter: first pending direction after the last one served. The 2-bit
  // index wraps naturally, and the fourth probe lands back on last itself.
  logic [1:0] probe;
  logic       found;

  always_comb begin
    next_dir = '0;
    found    = 1'b0;
    probe    = '0;
    for (int k = 1; k <= 4; k++) begin
      probe = last_q + 2'(k);
      if (!found && req_q[probe]) begin
        next_dir = probe;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    pending_cnt = '0;
    for (int i = 0; i < 4; i++) begin
      pending_cnt = pending_cnt + {2'b00, req_q[i]};
    end
  end

  assign req        = req_q;
  assign next_valid = |req_q;

endmodule

// File: tb/tb_traffic_request_conditioner.sv
// Self-checking bench for traffic_request_conditioner with DEBOUNCE_CYCLES = 4.
// The reference model keeps a short history of synchronised samples per
// button and commits a new debounced level once the last DEBOUNCE_CYCLES
// samples all disagree with it.

module tb_traffic_request_conditioner;

   localparam int D = 4;

   logic       clk;
   logic       rstN;
   logic [3:0] btn;
   logic [3:0] ack;
   logic [3:0] req;
   logic       nextValid;
   logic [1:0] nextDir;
   logic [2:0] pendingCnt;

   int checkCount = 0;
   int failCount  = 0;

   // Reference model state
   logic [3:0] mS1, mS2, mDb, mReq;
   logic [1:0] mLast;
   logic [3:0] hist [0:D-1];

   traffic_request_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
      .clk(clk),
      .rst(rstN),
      .btn(btn),
      .ack(ack),
      .req(req),
      .next_valid(nextValid),
      .next_dir(nextDir),
      .pending_cnt(pendingCnt)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      mS1 = '0; mS2 = '0; mDb = '0; mReq = '0; mLast = 2'd3;
      for (int k = 0; k < D; k++) hist[k] = '0;
   endtask

   // One rising edge of the reference, using pre-edge values.
   task automatic modelEdge(input logic [3:0] btnV, input logic [3:0] ackV);
      logic [3:0] press;
      logic [3:0] newDb;
      bit allDiff;
      for (int k = D-1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = mS2;
      press = '0;
      newDb = mDb;
      for (int ch = 0; ch < 4; ch++) begin
         allDiff = 1'b1;
         for (int k = 0; k < D; k++) if (hist[k][ch] == mDb[ch]) allDiff = 1'b0;
         if (allDiff) begin
            newDb[ch] = ~mDb[ch];
            press[ch] = ~mDb[ch];
         end
      end
      mReq = press | (mReq & ~ackV);
      for (int ch = 0; ch < 4; ch++) if (ackV[ch]) mLast = 2'(ch);
      mDb = newDb;
      mS2 = mS1;
      mS1 = btnV;
   endtask

   function automatic int expDir(input logic [3:0] r, input logic [1:0] l);
      for (int k = 1; k <= 4; k++) begin
         int idx;
         idx = (int'(l) + k) % 4;
         if (r[idx]) return idx;
      end
      return 0;
   endfunction

   task automatic compareAll();
      checkOutput("req", int'(req), int'(mReq));
      checkOutput("next_valid", int'(nextValid), int'(mReq != 4'h0));
      if (mReq != 4'h0) checkOutput("next_dir", int'(nextDir), expDir(mReq, mLast));
      checkOutput("pending_cnt", int'(pendingCnt), $countones(mReq));
   endtask

   // Drive one cycle of inputs, let an edge pass, then compare against the model.
   task automatic applyStimulus(input logic [3:0] btnV, input logic [3:0] ackV);
      btn = btnV;
      ack = ackV;
      @(posedge clk);
      if (rstN) modelEdge(btnV, ackV);
      #1;
      compareAll();
   endtask

   task automatic asyncReset();
      #2;
      rstN = 1'b0;
      #1;
      modelReset();
      checkOutput("reset_req", int'(req), 0);
      checkOutput("reset_valid", int'(nextValid), 0);
      checkOutput("reset_dir", int'(nextDir), 0);
      checkOutput("reset_cnt", int'(pendingCnt), 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(4'h0, 4'h0);
   endtask

   initial begin
      logic [3:0] bounce [0:11];
      logic [3:0] btnR;
      logic [3:0] ackR;
      int r;

      rstN = 1'b0;
      btn  = '0;
      ack  = '0;
      modelReset();
      #12;
      compareAll();
      @(posedge clk);
      #1;
      rstN = 1'b1;

      // Reset mid-run with all buttons held, then debounce afresh.
      $display("[TB] reset scenario");
      for (int i = 0; i < 8; i++) applyStimulus(4'hF, 4'h0);
      asyncReset();
      applyStimulus(4'hF, 4'h0);
      applyStimulus(4'hF, 4'h0);
      rstN = 1'b1;
      for (int e = 0; e <= 5; e++) begin
         applyStimulus(4'hF, 4'h0);
         if (e == 4) checkOutput("rst_edge4_req", int'(req), 0);
         if (e == 5) begin
            checkOutput("rst_edge5_req", int'(req), 15);
            checkOutput("rst_edge5_cnt", int'(pendingCnt), 4);
            checkOutput("rst_edge5_dir", int'(nextDir), 0);
         end
      end
      idle(8);
      checkOutput("release_keeps_req", int'(req), 15);
      applyStimulus(4'h0, 4'h1);
      applyStimulus(4'h0, 4'h2);
      applyStimulus(4'h0, 4'h4);
      applyStimulus(4'h0, 4'h8);
      checkOutput("all_acked", int'(req), 0);

      // Short pulse is filtered, long hold latches at edge 5.
      $display("[TB] debounce scenario");
      for (int i = 0; i < 3; i++) applyStimulus(4'h2, 4'h0);
      idle(8);
      checkOutput("short_pulse", int'(req), 0);
      for (int e = 0; e < 10; e++) begin
         applyStimulus(4'h2, 4'h0);
         if (e == 4) checkOutput("hold_edge4", int'(req), 0);
         if (e == 5) checkOutput("hold_edge5", int'(req), 2);
      end
      idle(8);
      checkOutput("release_silent", int'(req), 2);
      applyStimulus(4'h0, 4'h2);

      // Bounce on south restarts the count.
      $display("[TB] bounce scenario");
      bounce = '{4'h4, 4'h4, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4};
      for (int e = 0; e < 12; e++) begin
         applyStimulus(bounce[e], 4'h0);
         if (e == 7) checkOutput("bounce_edge7", int'(req), 0);
         if (e == 8) checkOutput("bounce_edge8", int'(req), 4);
      end
      idle(8);
      applyStimulus(4'h0, 4'h4);

      // Round-robin: idle ack on W brings last back to 3.
      $display("[TB] round-robin scenario");
      applyStimulus(4'h0, 4'h8);
      for (int i = 0; i < 6; i++) applyStimulus(4'hB, 4'h0);
      idle(8);
      checkOutput("rr_req", int'(req), 11);
      checkOutput("rr_dir0", int'(nextDir), 0);
      applyStimulus(4'h0, 4'h1);
      checkOutput("rr_dir1", int'(nextDir), 1);
      applyStimulus(4'h0, 4'h2);
      checkOutput("rr_dir3", int'(nextDir), 3);
      applyStimulus(4'h0, 4'h8);
      checkOutput("rr_empty", int'(nextValid), 0);

      // Multi-bit ack.
      $display("[TB] multi-ack scenario");
      for (int i = 0; i < 6; i++) applyStimulus(4'hF, 4'h0);
      idle(8);
      applyStimulus(4'h0, 4'h5);
      checkOutput("multi_req", int'(req), 10);
      checkOutput("multi_dir", int'(nextDir), 3);
      checkOutput("multi_cnt", int'(pendingCnt), 2);

      // Press commit coinciding with ack on the same bit.
      $display("[TB] collision scenario");
      for (int i = 0; i < 5; i++) applyStimulus(4'h1, 4'h0);
      applyStimulus(4'h1, 4'h1);
      checkOutput("collide_req", int'(req), 11);
      checkOutput("collide_dir", int'(nextDir), 1);
      idle(8);
      applyStimulus(4'h0, 4'h4);
      checkOutput("idle_ack_req", int'(req), 11);
      checkOutput("idle_ack_dir", int'(nextDir), 3);

      // Randomised traffic with occasional asynchronous resets.
      $display("[TB] random scenario");
      btnR = '0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 399) == 0) begin
            asyncReset();
            applyStimulus(btnR, 4'h0);
            rstN = 1'b1;
         end
         if ($urandom_range(0, 5) == 0) btnR[$urandom_range(0, 3)] ^= 1'b1;
         r = int'($urandom_range(0, 9));
         if (r < 3)       ackR = 4'(1 << $urandom_range(0, 3));
         else if (r == 3) ackR = 4'($urandom_range(0, 15));
         else             ackR = 4'h0;
         applyStimulus(btnR, ackR);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
